// File: rtl/glyph_shifter.sv
// Two-stage text-mode pixel pipeline: ROM row select, then MSB-first glyph
// shift and RGB332 colouring. Optional blink masking under `GLYPH_BLINK_EN.
module glyph_shifter (
  input  logic       clk,
  input  logic       reset,
  input  logic       pixel_tick,
  input  logic       video_on,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic [7:0] rom_data,
  input  logic [7:0] fg_color,
  input  logic [7:0] bg_color,
  input  logic       blink_req,
  output logic [3:0] rom_row,
  output logic [7:0] rgb,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       glyph_pix
);

  logic [2:0] r_xq1;
  logic       r_von1;
  logic       r_hs1;
  logic       r_vs1;
  logic [7:0] r_sreg;

  logic       w_load;
  logic       w_bit;
  logic       w_mask;
  logic [7:0] w_sreg_next;
  logic [7:0] w_rgb_next;

  // Only the in-cell column and in-row line are used by the pipeline.
  logic w_unused_coords;
  assign w_unused_coords = ^{pixel_x[9:3], pixel_y[9:4]};

`ifdef GLYPH_BLINK_EN
  logic [5:0] r_blink_cnt;
  logic       w_vs_fall;

  // r_vs1 holds vsync_in from the previous pixel_tick, so this is the
  // falling edge as seen at pixel rate.
  assign w_vs_fall = r_vs1 & ~vsync_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_blink_cnt <= '0;
    end else if (pixel_tick && w_vs_fall) begin
      r_blink_cnt <= r_blink_cnt + 6'd1;
    end
  end

  assign w_mask = blink_req & r_blink_cnt[5];
`else
  logic w_unused_blink;
  assign w_unused_blink = blink_req;
  assign w_mask         = 1'b0;
`endif

  always_comb begin
    w_load      = (r_xq1 == 3'd0);
    w_bit       = w_load ? rom_data[7] : r_sreg[6];
    w_sreg_next = w_load ? rom_data : {r_sreg[6:0], 1'b0};
    w_rgb_next  = '0;
    if (r_von1) begin
      w_rgb_next = (w_bit && !w_mask) ? fg_color : bg_color;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rom_row   <= '0;
      r_xq1     <= '0;
      r_von1    <= 1'b0;
      r_hs1     <= 1'b1;
      r_vs1     <= 1'b1;
      r_sreg    <= '0;
      glyph_pix <= 1'b0;
      rgb       <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else if (pixel_tick) begin
      rom_row   <= pixel_y[3:0];
      r_xq1     <= pixel_x[2:0];
      r_von1    <= video_on;
      r_hs1     <= hsync_in;
      r_vs1     <= vsync_in;
      r_sreg    <= w_sreg_next;
      glyph_pix <= w_bit;
      rgb       <= w_rgb_next;
      hsync_out <= r_hs1;
      vsync_out <= r_vs1;
    end
  end

endmodule

// File: doc/glyph_shifter.md
GLYPH_SHIFTER -- requirements
Module: glyph_shifter

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 reset  input  1  reset, synchronous, active-high.
REQ-003 pixel_tick  input  1  pixel-rate enable, one clk wide; pipeline advances only when high.
REQ-004 video_on  input  1  current pixel inside visible area.
REQ-005 hsync_in, vsync_in  input  1 each  raw sync from the VGA timing generator; vsync_in active-low.
REQ-006 pixel_x, pixel_y  input  10 each  current pixel coordinate.
REQ-007 rom_data  input  8  glyph row from the character ROM, combinational response to rom_row, MSB = leftmost pixel.
REQ-008 fg_color, bg_color  input  8 each  RGB332 foreground and background.
REQ-009 blink_req  input  1  request blinking of glyph pixels (alarm ring).
REQ-010 rom_row  output  4  registered glyph row index sent to the ROM row-select input.
REQ-011 rgb  output  8  registered pixel colour.
REQ-012 hsync_out, vsync_out  output  1 each  sync delayed to align with rgb.
REQ-013 glyph_pix  output  1  registered glyph bit of the displayed pixel, before colouring.

Function
REQ-014 Stage 1, on pixel_tick: rom_row <= pixel_y[3:0]; xq1 <= pixel_x[2:0]; von1 <= video_on; hs1/vs1 <= hsync_in/vsync_in.
REQ-015 rom_data is sampled at stage 2 of the same tick chain, one pixel_tick after rom_row was updated.
REQ-016 Stage 2, on pixel_tick, when xq1 == 0: sreg <= rom_data and glyph_pix <= rom_data[7].
REQ-017 Stage 2, on pixel_tick, when xq1 != 0: sreg <= {sreg[6:0],1'b0} and glyph_pix <= sreg[6].
- Net effect: an 8-bit row is shifted out MSB first over 8 ticks.
REQ-018 Stage 2, on pixel_tick: von2 <= von1; hsync_out <= hs1; vsync_out <= vs1.
REQ-019 rgb <= 8'h00 when von1 == 0.
REQ-020 Otherwise rgb <= fg_color when the glyph bit is 1 and it is not masked by blink; else rgb <= bg_color.
REQ-021 Total latency is exactly 2 pixel_ticks from the pixel_x/pixel_y/sync inputs to the corresponding rgb, glyph_pix and sync outputs.
REQ-022 pixel_tick low: every register holds its value, including sreg.
REQ-023 Column boundary: a load (xq1 == 0) takes priority over a shift on the same tick; the row never bleeds into the next cell.
REQ-024 Horizontal wrap: at pixel_x 799 -> 0, the load at xq1 == 0 starts the new line's first cell with no residual bits.
REQ-025 Vertical wrap: pixel_y[3:0] rolls over naturally, 15 -> 0.
REQ-026 fg_color and bg_color are sampled at stage 2 and take effect on the next rgb update.

Reset
REQ-027 When reset is high on a clk edge, regardless of pixel_tick: rgb = 0, glyph_pix = 0, rom_row = 0, sreg = 0, xq1 = 0, von1 = von2 = 0.
REQ-028 During the same reset: hsync_out = 1, vsync_out = 1, hs1 = vs1 = 1 (inactive), blink counter = 0.
REQ-029 Reset asserted mid-line aborts the current cell immediately.
REQ-030 After reset release, the first valid rgb appears 2 pixel_ticks later; until then rgb = 0.

Configuration
REQ-031 Macro GLYPH_BLINK_EN defined: a 6-bit frame counter increments on each falling edge of vsync_in sampled at pixel_tick, wrapping 63 -> 0.
REQ-032 GLYPH_BLINK_EN defined: when blink_req = 1 and counter[5] = 1, glyph pixels render as bg_color; otherwise normal.
- Blink period is 64 frames, 50% duty.
REQ-033 GLYPH_BLINK_EN defined: a blink_req change takes effect at the next stage-2 tick.
REQ-034 GLYPH_BLINK_EN undefined: no counter is built, blink_req is ignored, and REQ-020 applies with no masking.

Verification
REQ-035 Reset: hold reset 3 clk with pixel_tick = 1 -> rgb = 0, rom_row = 0, hsync_out = vsync_out = 1; the first non-zero rgb occurs no earlier than the 2nd tick after release.
REQ-036 Shift: video_on = 1, pixel_y = 5, ROM model returns 8'b01000010 for row 5, fg = 8'hFF, bg = 8'h03, x = 0..7 -> rgb over ticks 2..9 = 03,FF,03,03,03,03,FF,03; rom_row = 5.
REQ-037 Stall: same as REQ-036 with pixel_tick low for 5 clk after x = 3 -> outputs frozen, then the sequence resumes with no lost or duplicated pixel.
REQ-038 Blank and wrap: video_on = 0 at x = 640..799 -> rgb = 0; the cell at x = 0 of the next line loads fresh data with no residue from x = 639.
REQ-039 Sync alignment: hsync_in falling at tick N -> hsync_out falling at tick N+2.
REQ-040 GLYPH_BLINK_EN: blink_req = 1 and 32 vsync pulses -> glyph pixels equal bg_color for frames 32..63 and fg_color for frames 0..31; without the macro, always fg_color.
